instr_decode_stage: RTL and testbench
=====================================

INSTR_DECODE_STAGE -- requirements
Module: instr_decode_stage

Interface
REQ-001 SHALL have parameter INSTR_W, default 16, instruction word width.
REQ-002 SHALL have parameter OPC_W, default 4, opcode field width.
REQ-003 SHALL have parameter REG_W, default 4, register-index field width; INSTR_W SHALL equal OPC_W+3*REG_W.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 flush  input  1  synchronous discard of held/partial instruction.
REQ-007 in_valid  input  1  in_instr valid.
REQ-008 in_ready  output  1  stage accepts in_instr this cycle.
REQ-009 in_instr  input  INSTR_W  instruction word.
REQ-010 out_valid  output  1  decoded bundle valid.
REQ-011 out_ready  input  1  consumer accepts bundle.
REQ-012 out_opcode  output  OPC_W  opcode.
REQ-013 out_fmt  output  3  one-hot-free code: 0=R, 1=I, 2=J, 3=X (extended), 4=ILLEGAL.
REQ-014 out_reg1/out_reg2/out_reg3  output  REG_W each  register indices.
REQ-015 out_imm  output  INSTR_W  immediate, zero-extended.
REQ-016 out_jump  output  INSTR_W-OPC_W  jump target.

Function
REQ-017 Fields: opcode=instr[MSB -: OPC_W]; F1,F2,F3 = successive REG_W slices below it, F3 at LSB.
REQ-018 Opcode 1 (R): reg1=F1, reg2=F2, reg3=F3; imm=0, jump=0.
REQ-019 Opcode 2 or 3 (I): reg1=F1, reg2=F2, imm=zero-extended {F2,F3}; reg3=0, jump=0.
REQ-020 Opcode 4 (J): jump=instr[INSTR_W-OPC_W-1:0]; regs=0, imm=0.
REQ-021 Any other opcode: fmt=ILLEGAL, opcode passed through, all other fields 0; bundle still emitted.
REQ-022 Every field not named for a format SHALL be driven 0; no output holds a stale value.
REQ-023 Output is one register stage: accepted word at edge N appears on out_* with out_valid=1 after edge N (latency 1).
REQ-024 in_ready = !out_valid || out_ready (combinational); a transfer occurs when valid && ready on each side.
REQ-025 out_* SHALL be stable while out_valid=1 && out_ready=0.
REQ-026 Simultaneous output drain and input accept in one cycle SHALL sustain one instruction per cycle.
REQ-027 FSM states FIRST, EXT; reset state FIRST.
REQ-028 FIRST: accepted non-extended word -> load output, stay FIRST.
REQ-029 FIRST: accepted opcode 5 word (extension enabled) -> latch opcode and F1, no output, go EXT; in_ready=1 in EXT while waiting.
REQ-030 EXT: accepted word -> emit fmt=X, reg1=latched F1, imm=full second word, reg2=reg3=jump=0; go FIRST.
REQ-031 flush=1 -> clear out_valid, discard latched partial, go FIRST; in_valid ignored that cycle; flush overrides all.

Reset
REQ-032 rst_n=0 SHALL immediately force out_valid=0, state FIRST, all out_* fields 0, latched partial 0, independent of clk.
REQ-033 Reset mid-EXT SHALL discard first word; next accepted word decodes as a fresh instruction.
REQ-034 in_ready SHALL be 1 from the first cycle after reset release.

Configuration
REQ-035 Macro DECODE_EXT_EN defined: opcode 5 two-word extended-immediate decode per REQ-029/030 compiled in.
REQ-036 DECODE_EXT_EN undefined: no EXT state or latch; opcode 5 decodes as ILLEGAL in one word; fmt value 3 never produced.

Verification
REQ-037 Default params, in 0x1234, out_ready=1 -> next cycle out_valid=1, fmt=R, opcode=1, reg1=2, reg2=3, reg3=4, imm=0, jump=0.
REQ-038 In 0x2A5C then 0x4ABC back-to-back, out_ready=1 -> fmt=I reg1=A reg2=5 imm=0x005C, then fmt=J jump=0xABC regs=0; no bubble.
REQ-039 In 0x1111 with out_ready=0 for 3 cycles, in_valid held with 0x1222 -> in_ready=0, outputs hold 0x1111 decode; on release 0x1222 follows next cycle.
REQ-040 DECODE_EXT_EN: in 0x5700 then 0xBEEF -> no output after first word; after second fmt=X reg1=7 imm=0xBEEF.
REQ-041 DECODE_EXT_EN: 0x5700 then flush=1, then 0x0FFF -> nothing emitted for 0x5700; 0x0FFF -> fmt=ILLEGAL, opcode=0, fields 0.
REQ-042 rst_n low asynchronously mid-EXT and while out_valid=1 -> out_valid=0 immediately; after release 0x3123 -> fmt=I reg1=1 reg2=2 imm=0x0023.

Source files
------------

// File: rtl/instr_decode_stage_if.sv
// Handshake bundle between fetch, the decode stage and its consumer.
// master: instruction source / bundle sink; slave: the decode stage.
interface instr_decode_stage_if #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int REG_W   = 4
);
  logic                     in_valid;
  logic                     in_ready;
  logic [INSTR_W-1:0]       in_instr;
  logic                     out_valid;
  logic                     out_ready;
  logic [OPC_W-1:0]         out_opcode;
  logic [2:0]               out_fmt;
  logic [REG_W-1:0]         out_reg1;
  logic [REG_W-1:0]         out_reg2;
  logic [REG_W-1:0]         out_reg3;
  logic [INSTR_W-1:0]       out_imm;
  logic [INSTR_W-OPC_W-1:0] out_jump;

  modport master (
    output in_valid, in_instr, out_ready,
    input  in_ready, out_valid, out_opcode, out_fmt,
    input  out_reg1, out_reg2, out_reg3, out_imm, out_jump
  );

  modport slave (
    input  in_valid, in_instr, out_ready,
    output in_ready, out_valid, out_opcode, out_fmt,
    output out_reg1, out_reg2, out_reg3, out_imm, out_jump
  );
endinterface

// File: rtl/instr_decode_stage.sv
// Single-register instruction decode stage with valid/ready handshake.
// Define DECODE_EXT_EN for two-word extended-immediate decode (opcode 5).
module instr_decode_stage #(
  parameter int INSTR_W = 16,
  parameter int OPC_W   = 4,
  parameter int REG_W   = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  instr_decode_stage_if.slave bus
);
  localparam int JMP_W = INSTR_W - OPC_W;
  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_J   = 3'd2;
  localparam logic [2:0] FMT_ILL = 3'd4;

  logic [OPC_W-1:0]   opc;
  logic [REG_W-1:0]   f1, f2, f3;
  logic               accept, load;
  logic [2:0]         b_fmt;
  logic [REG_W-1:0]   b_r1, b_r2, b_r3;
  logic [INSTR_W-1:0] b_imm;
  logic [JMP_W-1:0]   b_jump;
  logic [OPC_W-1:0]   d_opc;
  logic [2:0]         d_fmt;
  logic [REG_W-1:0]   d_r1, d_r2, d_r3;
  logic [INSTR_W-1:0] d_imm;
  logic [JMP_W-1:0]   d_jump;

  assign opc = bus.in_instr[INSTR_W-1 -: OPC_W];
  assign f1  = bus.in_instr[3*REG_W-1 -: REG_W];
  assign f2  = bus.in_instr[2*REG_W-1 -: REG_W];
  assign f3  = bus.in_instr[REG_W-1:0];

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept = bus.in_valid && bus.in_ready && !flush;

  always_comb begin
    b_fmt  = FMT_ILL;
    b_r1   = '0;
    b_r2   = '0;
    b_r3   = '0;
    b_imm  = '0;
    b_jump = '0;
    unique case (1'b1)
      opc == OPC_W'(1): begin
        b_fmt = FMT_R;
        b_r1  = f1;
        b_r2  = f2;
        b_r3  = f3;
      end
      opc == OPC_W'(2), opc == OPC_W'(3): begin
        b_fmt = FMT_I;
        b_r1  = f1;
        b_r2  = f2;
        b_imm = INSTR_W'({f2, f3});
      end
      opc == OPC_W'(4): begin
        b_fmt  = FMT_J;
        b_jump = bus.in_instr[JMP_W-1:0];
      end
      default: ;
    endcase
  end

`ifdef DECODE_EXT_EN
  localparam logic [2:0] FMT_X = 3'd3;

  typedef enum logic {FIRST, EXT} state_t;

  state_t           state, state_nx;
  logic             latch;
  logic [OPC_W-1:0] x_opc;
  logic [REG_W-1:0] x_f1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= FIRST;
      x_opc <= '0;
      x_f1  <= '0;
    end else begin
      state <= state_nx;
      if (flush) begin
        x_opc <= '0;
        x_f1  <= '0;
      end else if (latch) begin
        x_opc <= opc;
        x_f1  <= f1;
      end
    end
  end

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    latch    = 1'b0;
    d_opc    = opc;
    d_fmt    = b_fmt;
    d_r1     = b_r1;
    d_r2     = b_r2;
    d_r3     = b_r3;
    d_imm    = b_imm;
    d_jump   = b_jump;
    if (flush) begin
      state_nx = FIRST;
    end else if (accept) begin
      unique case (state)
        FIRST: begin
          if (opc == OPC_W'(5)) begin
            latch    = 1'b1;
            state_nx = EXT;
          end else begin
            load = 1'b1;
          end
        end
        EXT: begin
          load     = 1'b1;
          state_nx = FIRST;
          d_opc    = x_opc;
          d_fmt    = FMT_X;
          d_r1     = x_f1;
          d_r2     = '0;
          d_r3     = '0;
          d_imm    = bus.in_instr;
          d_jump   = '0;
        end
      endcase
    end
  end
`else
  always_comb begin
    load   = accept;
    d_opc  = opc;
    d_fmt  = b_fmt;
    d_r1   = b_r1;
    d_r2   = b_r2;
    d_r3   = b_r3;
    d_imm  = b_imm;
    d_jump = b_jump;
  end
`endif

  // Fields are zeroed whenever the bundle is not valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.out_valid  <= 1'b0;
      bus.out_opcode <= '0;
      bus.out_fmt    <= '0;
      bus.out_reg1   <= '0;
      bus.out_reg2   <= '0;
      bus.out_reg3   <= '0;
      bus.out_imm    <= '0;
      bus.out_jump   <= '0;
    end else if (load) begin
      bus.out_valid  <= 1'b1;
      bus.out_opcode <= d_opc;
      bus.out_fmt    <= d_fmt;
      bus.out_reg1   <= d_r1;
      bus.out_reg2   <= d_r2;
      bus.out_reg3   <= d_r3;
      bus.out_imm    <= d_imm;
      bus.out_jump   <= d_jump;
    end else if (flush || bus.out_ready) begin
      bus.out_valid  <= 1'b0;
      bus.out_opcode <= '0;
      bus.out_fmt    <= '0;
      bus.out_reg1   <= '0;
      bus.out_reg2   <= '0;
      bus.out_reg3   <= '0;
      bus.out_imm    <= '0;
      bus.out_jump   <= '0;
    end
  end
endmodule

// File: tb/tb_instr_decode_stage.sv
// Scoreboard bench for instr_decode_stage (default parameters).
// Build with or without DECODE_EXT_EN; the ext scenarios follow the macro.
module tb_instr_decode_stage;
  typedef struct packed {
    logic [3:0]  opc;
    logic [2:0]  fmt;
    logic [3:0]  r1;
    logic [3:0]  r2;
    logic [3:0]  r3;
    logic [15:0] imm;
    logic [11:0] jump;
  } exp_t;

`ifdef DECODE_EXT_EN
  localparam bit EXT_ON = 1'b1;
`else
  localparam bit EXT_ON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  instr_decode_stage_if #(.INSTR_W(16), .OPC_W(4), .REG_W(4)) bus ();

  instr_decode_stage #(.INSTR_W(16), .OPC_W(4), .REG_W(4)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .bus(bus)
  );

  always #5 clk = ~clk;

  exp_t       sb[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  bit         ext_pend = 1'b0;
  logic [3:0] ext_f1 = 4'h0;
  logic       ov, ir, xfer, miss;
  exp_t       got, want;

  function automatic exp_t mk(input logic [3:0] op, input logic [2:0] f,
                              input logic [3:0] a, input logic [3:0] b,
                              input logic [3:0] c, input logic [15:0] im,
                              input logic [11:0] jp);
    exp_t e;
    e.opc = op; e.fmt = f; e.r1 = a; e.r2 = b; e.r3 = c;
    e.imm = im; e.jump = jp;
    return e;
  endfunction

  function automatic exp_t dec(input logic [15:0] w);
    exp_t e = '0;
    e.opc = w[15:12];
    e.fmt = 3'd4;
    case (w[15:12])
      4'd1: begin
        e.fmt = 3'd0; e.r1 = w[11:8]; e.r2 = w[7:4]; e.r3 = w[3:0];
      end
      4'd2, 4'd3: begin
        e.fmt = 3'd1; e.r1 = w[11:8]; e.r2 = w[7:4];
        e.imm = {8'h00, w[7:0]};
      end
      4'd4: begin
        e.fmt = 3'd2; e.jump = w[11:0];
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t obs();
    return mk(bus.out_opcode, bus.out_fmt, bus.out_reg1, bus.out_reg2,
              bus.out_reg3, bus.out_imm, bus.out_jump);
  endfunction

  // One clock cycle: drive, sample at negedge, update the scoreboard.
  task automatic step(input logic v, input logic [15:0] w,
                      input logic ordy, input logic fl);
    bus.in_valid  = v;
    bus.in_instr  = w;
    bus.out_ready = ordy;
    flush         = fl;
    @(negedge clk);
    ov   = bus.out_valid;
    ir   = bus.in_ready;
    got  = obs();
    xfer = ov && ordy && !fl;
    miss = 1'b0;
    want = '0;
    if (xfer) begin
      if (sb.size() == 0) miss = 1'b1;
      else want = sb.pop_front();
    end
    if (fl) begin
      ext_pend = 1'b0;
    end else if (v && ir) begin
      if (ext_pend) begin
        sb.push_back(mk(4'd5, 3'd3, ext_f1, 4'h0, 4'h0, w, 12'h000));
        ext_pend = 1'b0;
      end else if (EXT_ON && w[15:12] == 4'd5) begin
        ext_pend = 1'b1;
        ext_f1   = w[11:8];
      end else begin
        sb.push_back(dec(w));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    bus.in_valid = 1'b0; bus.in_instr = '0; bus.out_ready = 1'b1;
    #12;
    n_cmp++;
    if (bus.out_valid !== 1'b0) begin
      n_bad++; $display("FAIL reset_valid: got %b want 0", bus.out_valid);
    end
    n_cmp++;
    if (obs() !== exp_t'(0)) begin
      n_bad++; $display("FAIL reset_fields: got %h want 0", obs());
    end
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_bad++; $display("FAIL reset_ready: got %b want 1", bus.in_ready);
    end
  endtask

  task automatic test_r_format();
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    n_cmp++;
    if (!xfer || miss || got !== want) begin
      n_bad++; $display("FAIL r_sb: got %h want %h", got, want);
    end
    n_cmp++;
    if (got !== mk(4'd1, 3'd0, 4'd2, 4'd3, 4'd4, 16'h0, 12'h0)) begin
      n_bad++; $display("FAIL r_const: got %h want R 1/2/3/4", got);
    end
  endtask

  task automatic test_back_to_back();
    step(1'b1, 16'h2A5C, 1'b1, 1'b0);
    step(1'b1, 16'h4ABC, 1'b1, 1'b0);
    n_cmp++;
    if (!xfer || miss || got !== want) begin
      n_bad++; $display("FAIL b2b_i_sb: got %h want %h", got, want);
    end
    n_cmp++;
    if (got !== mk(4'd2, 3'd1, 4'hA, 4'h5, 4'h0, 16'h005C, 12'h0)) begin
      n_bad++; $display("FAIL b2b_i_const: got %h", got);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    n_cmp++;
    if (!xfer || miss || got !== want) begin
      n_bad++; $display("FAIL b2b_j_sb: got %h want %h xfer %b", got, want, xfer);
    end
    n_cmp++;
    if (got !== mk(4'd4, 3'd2, 4'h0, 4'h0, 4'h0, 16'h0, 12'hABC)) begin
      n_bad++; $display("FAIL b2b_j_const: got %h", got);
    end
  endtask

  task automatic test_stall();
    step(1'b1, 16'h1111, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 16'h1222, 1'b0, 1'b0);
      n_cmp++;
      if (ir !== 1'b0 || ov !== 1'b1) begin
        n_bad++; $display("FAIL stall_hs: got rdy %b vld %b want 0 1", ir, ov);
      end
      n_cmp++;
      if (got !== mk(4'd1, 3'd0, 4'd1, 4'd1, 4'd1, 16'h0, 12'h0)) begin
        n_bad++; $display("FAIL stall_hold: got %h", got);
      end
    end
    step(1'b1, 16'h1222, 1'b1, 1'b0);
    n_cmp++;
    if (!xfer || miss || got !== want || ir !== 1'b1) begin
      n_bad++; $display("FAIL stall_rel: got %h want %h rdy %b", got, want, ir);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    n_cmp++;
    if (!xfer || got !== mk(4'd1, 3'd0, 4'd2, 4'd2, 4'd2, 16'h0, 12'h0)) begin
      n_bad++; $display("FAIL stall_next: got %h xfer %b", got, xfer);
    end
  endtask

  task automatic test_illegal();
    logic [3:0] prev = 4'h0;
    bit         have = 1'b0;
    for (int op = 0; op < 17; op++) begin
      logic [3:0] o4 = op[3:0];
      if (op < 16 && (op == 1 || op == 2 || op == 3 || op == 4 ||
                      (EXT_ON && op == 5)))
        continue;
      step(op < 16, {o4, 12'hFFF}, 1'b1, 1'b0);
      if (have) begin
        n_cmp++;
        if (!xfer || miss || got !== want ||
            got !== mk(prev, 3'd4, 4'h0, 4'h0, 4'h0, 16'h0, 12'h0)) begin
          n_bad++; $display("FAIL illegal_op%0d: got %h want %h", prev, got, want);
        end
      end
      prev = o4;
      have = 1'b1;
    end
  endtask

  task automatic test_random();
    for (int k = 0; k < 80; k++) begin
      step(1'($urandom_range(0, 1)), 16'($urandom),
           $urandom_range(0, 3) != 0, 1'b0);
      if (xfer) begin
        n_cmp++;
        if (miss || got !== want) begin
          n_bad++; $display("FAIL rand_%0d: got %h want %h", k, got, want);
        end
      end
    end
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 16'h0000, 1'b1, 1'b0);
      if (xfer) begin
        n_cmp++;
        if (miss || got !== want) begin
          n_bad++; $display("FAIL rand_drain: got %h want %h", got, want);
        end
      end
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++; $display("FAIL rand_left: got %0d want 0", sb.size());
      sb.delete();
    end
    step(1'b0, 16'h0000, 1'b1, 1'b1);
  endtask

  task automatic test_ext();
    step(1'b1, 16'h5700, 1'b1, 1'b0);
    step(1'b1, 16'hBEEF, 1'b1, 1'b0);
`ifdef DECODE_EXT_EN
    n_cmp++;
    if (ov !== 1'b0) begin
      n_bad++; $display("FAIL ext_first: got vld %b want 0", ov);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    n_cmp++;
    if (!xfer || miss || got !== want ||
        got !== mk(4'd5, 3'd3, 4'd7, 4'h0, 4'h0, 16'hBEEF, 12'h0)) begin
      n_bad++; $display("FAIL ext_x: got %h want %h", got, want);
    end
    step(1'b1, 16'h5700, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b1);
    step(1'b1, 16'h0FFF, 1'b1, 1'b0);
    n_cmp++;
    if (ov !== 1'b0) begin
      n_bad++; $display("FAIL flush_none: got vld %b want 0", ov);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    n_cmp++;
    if (!xfer || got !== mk(4'd0, 3'd4, 4'h0, 4'h0, 4'h0, 16'h0, 12'h0)) begin
      n_bad++; $display("FAIL flush_ill: got %h xfer %b", got, xfer);
    end
`else
    n_cmp++;
    if (!xfer || got !== mk(4'd5, 3'd4, 4'h0, 4'h0, 4'h0, 16'h0, 12'h0)) begin
      n_bad++; $display("FAIL noext_ill: got %h xfer %b", got, xfer);
    end
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    n_cmp++;
    if (!xfer || miss || got !== want || got.fmt === 3'd3) begin
      n_bad++; $display("FAIL noext_2nd: got %h want %h", got, want);
    end
`endif
  endtask

  task automatic test_async_reset();
    step(1'b1, 16'h1234, 1'b1, 1'b0);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 1'b0 || obs() !== exp_t'(0)) begin
      n_bad++; $display("FAIL arst_valid: got %b %h want 0", bus.out_valid, obs());
    end
    sb.delete();
    ext_pend = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 16'h5700, 1'b1, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    sb.delete();
    ext_pend = 1'b0;
    #3;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step(1'b1, 16'h3123, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 1'b1, 1'b0);
    n_cmp++;
    if (!xfer || miss || got !== want ||
        got !== mk(4'd3, 3'd1, 4'd1, 4'd2, 4'd0, 16'h0023, 12'h0)) begin
      n_bad++; $display("FAIL arst_fresh: got %h want %h", got, want);
    end
  endtask

  initial begin
    test_reset();
    test_r_format();
    test_back_to_back();
    test_stall();
    test_illegal();
    test_ext();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
